// File: rtl/video_shifter.sv
// Palette-based video pixel shifter: serialises display bytes at 1/2/4 bpp,
// looks colours up in a 16-entry palette, applies flash and cursor effects.
module video_shifter #(
  parameter int                  COLOUR_W     = 3,
  parameter int                  FLASH_FRAMES = 25,
  parameter logic [COLOUR_W-1:0] CUR_XOR      = '1
) (
  input  logic                clk16MHz,
  input  logic                RESET,
  input  logic                cfg_we,
  input  logic                cfg_addr,
  input  logic [7:0]          cfg_data,
  input  logic                LOAD,
  input  logic [7:0]          DATA,
  input  logic                DISEN,
  input  logic                CURSOR,
  input  logic                VSYNC,
  output logic [COLOUR_W-1:0] RGB
);

  localparam logic [7:0] FRAME_LAST = 8'(FLASH_FRAMES - 1);

  logic [7:0]          ctrl_q;
  logic [COLOUR_W:0]   pal_q [16];
  logic [7:0]          sr_q, sr_d;
  logic [2:0]          div_q, div_d;
  logic [7:0]          frame_q, frame_d;
  logic                phase_q, phase_d;
  logic                vs_q;
  logic [2:0]          cur_q, cur_d;
  logic [COLOUR_W-1:0] rgb_q, rgb_d;

  logic [3:0]          pix_idx;
  logic [7:0]          sr_shifted;
  logic                tick;
  logic [COLOUR_W:0]   entry;
  logic [COLOUR_W-1:0] colour;
  logic [2:0]          cur_width;
  logic [COLOUR_W+2:0] cfg_colour_ext;

  assign cfg_colour_ext = {{COLOUR_W{1'b0}}, cfg_data[2:0]};

  always_comb begin
    pix_idx    = sr_q[7:4];
    sr_shifted = {sr_q[3:0], 4'b0000};
    case (ctrl_q[1:0])
      2'b00: begin
        pix_idx    = {3'b000, sr_q[7]};
        sr_shifted = {sr_q[6:0], 1'b0};
      end
      2'b01: begin
        pix_idx    = {2'b00, sr_q[7:6]};
        sr_shifted = {sr_q[5:0], 2'b00};
      end
      default: ;
    endcase

    // A tick ends a pixel period: the divider is zeroed by LOAD, so shifting
    // when the next count wraps gives the first pixel a full period.
    tick = 1'b1;
    case (ctrl_q[3:2])
      2'b00:   tick = &div_q;
      2'b01:   tick = &div_q[1:0];
      2'b10:   tick = div_q[0];
      default: tick = 1'b1;
    endcase

    cur_width = 3'd4;
    case (ctrl_q[7:6])
      2'b00:   cur_width = 3'd1;
      2'b01:   cur_width = 3'd2;
      default: cur_width = 3'd4;
    endcase

    entry  = pal_q[pix_idx];
    colour = entry[COLOUR_W-1:0];
    if (entry[COLOUR_W] && ctrl_q[4] && phase_q) colour = ~colour;
    if (ctrl_q[5] && (cur_q != 3'd0)) colour = colour ^ CUR_XOR;
    rgb_d = DISEN ? colour : '0;

    sr_d  = sr_q;
    div_d = div_q + 3'd1;
    if (LOAD) begin
      sr_d  = DATA;
      div_d = 3'd0;
    end else if (tick) begin
      sr_d = sr_shifted;
    end

    cur_d = cur_q;
    if (!ctrl_q[5]) begin
      cur_d = 3'd0;
    end else if (LOAD) begin
      if (CURSOR)              cur_d = cur_width;
      else if (cur_q != 3'd0)  cur_d = cur_q - 3'd1;
    end

    frame_d = frame_q;
    phase_d = phase_q;
    if (VSYNC && !vs_q) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = 8'd0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk16MHz) begin
    if (RESET) begin
      ctrl_q  <= 8'd0;
      for (int i = 0; i < 16; i++) pal_q[i] <= '0;
      sr_q    <= 8'd0;
      div_q   <= 3'd0;
      frame_q <= 8'd0;
      phase_q <= 1'b0;
      vs_q    <= 1'b0;
      cur_q   <= 3'd0;
      rgb_q   <= '0;
    end else begin
      if (cfg_we) begin
        if (!cfg_addr) ctrl_q <= cfg_data;
        else           pal_q[cfg_data[7:4]] <= {cfg_data[3], cfg_colour_ext[COLOUR_W-1:0]};
      end
      sr_q    <= sr_d;
      div_q   <= div_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      vs_q    <= VSYNC;
      cur_q   <= cur_d;
      rgb_q   <= rgb_d;
    end
  end

  assign RGB = rgb_q;

endmodule

// File: tb/tb_video_shifter.sv
// Self-checking bench for video_shifter: cycle model feeding an expected-RGB
// queue, plus directed pixel checks for the main display scenarios.
module tb_video_shifter;

  localparam int CW = 3;
  localparam int FF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic          cfg_addr;
  logic [7:0]    cfg_data;
  logic          load;
  logic [7:0]    data;
  logic          disen;
  logic          cursor;
  logic          vsync;
  logic [CW-1:0] rgb;

  always #5 clk = ~clk;

  video_shifter #(.COLOUR_W(CW), .FLASH_FRAMES(FF)) dut (
    .clk16MHz (clk),
    .RESET    (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .LOAD     (load),
    .DATA     (data),
    .DISEN    (disen),
    .CURSOR   (cursor),
    .VSYNC    (vsync),
    .RGB      (rgb)
  );

  logic [CW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_ctrl;
  logic [3:0] m_pal [16];
  logic [7:0] m_sr;
  int         m_div, m_frame, m_cur;
  bit         m_phase, m_vs;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [CW-1:0] exp;
    logic [3:0]    ent;
    logic [2:0]    col;
    int bpp, period, idx, width;
    exp = '0;
    if (rst) begin
      m_ctrl = 8'd0;
      for (int i = 0; i < 16; i++) m_pal[i] = 4'd0;
      m_sr = 8'd0; m_div = 0; m_frame = 0; m_cur = 0; m_phase = 0; m_vs = 0;
    end else begin
      bpp    = (m_ctrl[1:0] == 2'd0) ? 1 : (m_ctrl[1:0] == 2'd1) ? 2 : 4;
      period = 8 >> m_ctrl[3:2];
      width  = (m_ctrl[7:6] == 2'd0) ? 1 : (m_ctrl[7:6] == 2'd1) ? 2 : 4;
      idx    = int'(m_sr) >> (8 - bpp);
      ent    = m_pal[idx];
      col    = ent[2:0];
      if (ent[3] && m_ctrl[4] && m_phase) col = ~col;
      if (m_ctrl[5] && m_cur > 0) col = col ^ 3'b111;
      exp = disen ? col : 3'b000;
      if (!m_ctrl[5]) m_cur = 0;
      else if (load) m_cur = cursor ? width : ((m_cur > 0) ? m_cur - 1 : 0);
      if (load) m_sr = data;
      else if (((m_div + 1) % period) == 0) m_sr = m_sr << bpp;
      m_div = load ? 0 : (m_div + 1) % 8;
      if (vsync && !m_vs) begin
        if (m_frame == FF - 1) begin
          m_frame = 0;
          m_phase = ~m_phase;
        end else begin
          m_frame++;
        end
      end
      m_vs = vsync;
      if (cfg_we) begin
        if (!cfg_addr) m_ctrl = cfg_data;
        else           m_pal[cfg_data[7:4]] = cfg_data[3:0];
      end
    end
    exp_q.push_back(exp);
  endtask

  task automatic step();
    logic [CW-1:0] e;
    model_cycle();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_rgb", 8'(rgb), 8'(e));
    end
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; load = 0; data = 0;
    cursor = 0; vsync = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic cfg_write(input logic addr, input logic [7:0] d);
    cfg_we = 1; cfg_addr = addr; cfg_data = d;
    step();
    cfg_we = 0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic cur);
    load = 1; data = d; cursor = cur;
    step();
    load = 0; cursor = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1; disen = 0;

    // reset state and unconfigured display stays black
    step(); step();
    check_eq("reset_rgb", 8'(rgb), 8'h00);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      disen = 1'($urandom_range(0, 1));
      load  = 1'($urandom_range(0, 1));
      data  = 8'($urandom_range(0, 255));
      step();
      check_eq("noconfig_rgb", 8'(rgb), 8'h00);
    end

    // 4bpp, every cycle: pixel 8 then black
    do_reset();
    disen = 1;
    cfg_write(1'b0, 8'h0F);
    cfg_write(1'b1, 8'h85);
    load_byte(8'h80, 1'b0);
    step();
    check_eq("bpp4_px0", 8'(rgb), 8'h05);
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("bpp4_tail", 8'(rgb), 8'h00);
    end

    // 4bpp, every 2nd cycle: two pixels of two cycles each
    do_reset();
    disen = 1;
    cfg_write(1'b0, 8'h0A);
    cfg_write(1'b1, 8'h92);
    cfg_write(1'b1, 8'hF7);
    load_byte(8'h9F, 1'b0);
    step(); check_eq("rate2_a0", 8'(rgb), 8'h02);
    step(); check_eq("rate2_a1", 8'(rgb), 8'h02);
    step(); check_eq("rate2_b0", 8'(rgb), 8'h07);
    step(); check_eq("rate2_b1", 8'(rgb), 8'h07);
    step(); check_eq("rate2_end", 8'(rgb), 8'h00);

    // 1bpp and 2bpp ordering, every 4th cycle
    do_reset();
    disen = 1;
    cfg_write(1'b0, 8'h04);
    cfg_write(1'b1, 8'h13);
    load_byte(8'hA0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    cfg_write(1'b0, 8'h05);
    cfg_write(1'b1, 8'h26);
    load_byte(8'h9C, 1'b0);
    for (int i = 0; i < 20; i++) step();

    // flash: colour inverts after FF rising VSYNC edges, restores after FF more
    do_reset();
    disen = 1;
    cfg_write(1'b0, 8'h1F);
    cfg_write(1'b1, 8'h19);
    load = 1; data = 8'h11;
    step(); step(); step();
    check_eq("flash_off", 8'(rgb), 8'h01);
    for (int i = 0; i < FF; i++) begin
      vsync = 1; step(); vsync = 0; step();
    end
    step();
    check_eq("flash_on", 8'(rgb), 8'h06);
    for (int i = 0; i < FF; i++) begin
      vsync = 1; step(); vsync = 0; step();
    end
    step();
    check_eq("flash_back", 8'(rgb), 8'h01);
    load = 0;

    // cursor, width 2 LOADs
    do_reset();
    disen = 1;
    cfg_write(1'b0, 8'h6F);
    load_byte(8'($urandom_range(0, 255)), 1'b1);
    step(); check_eq("cur_p1", 8'(rgb), 8'h07);
    step(); step();
    load_byte(8'($urandom_range(0, 255)), 1'b0);
    step(); check_eq("cur_p2", 8'(rgb), 8'h07);
    step(); step();
    load_byte(8'($urandom_range(0, 255)), 1'b0);
    step(); check_eq("cur_p3", 8'(rgb), 8'h00);
    disen = 0;
    load_byte(8'h00, 1'b1);
    step(); check_eq("cur_disen0", 8'(rgb), 8'h00);

    // palette write in the same cycle as a lookup of that entry
    do_reset();
    disen = 1;
    cfg_write(1'b0, 8'h0F);
    cfg_write(1'b1, 8'h31);
    load_byte(8'h33, 1'b0);
    cfg_we = 1; cfg_addr = 1; cfg_data = 8'h36; load = 1; data = 8'h33;
    step();
    check_eq("pal_old", 8'(rgb), 8'h01);
    cfg_we = 0; load = 0;
    step();
    check_eq("pal_new", 8'(rgb), 8'h06);

    // reset mid-byte discards the remaining pixels
    do_reset();
    disen = 1;
    cfg_write(1'b0, 8'h0A);
    cfg_write(1'b1, 8'hF7);
    load_byte(8'hFF, 1'b0);
    step();
    check_eq("mid_px", 8'(rgb), 8'h07);
    rst = 1; load = 1; data = 8'hFF; cfg_we = 1; cfg_addr = 0; cfg_data = 8'hFF;
    step();
    check_eq("mid_reset", 8'(rgb), 8'h00);
    rst = 0; idle_inputs();
    step();
    check_eq("post_reset", 8'(rgb), 8'h00);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_addr = 1'($urandom_range(0, 1));
      cfg_data = 8'($urandom_range(0, 255));
      load     = ($urandom_range(0, 3) == 0);
      data     = 8'($urandom_range(0, 255));
      disen    = ($urandom_range(0, 7) != 0);
      cursor   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) vsync = ~vsync;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
